// File: rtl/dm_wait_slave.sv
// dm_wait_slave: data-memory responder with a req/ready handshake and
// WAIT_CYCLES programmable wait states in front of a word-wide synchronous RAM.
// Optional feature macro: DM_SLAVE_ERR_EN adds an err output and makes
// out-of-range reads return 32'hDEAD_BEEF instead of 32'h0.
module dm_wait_slave #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        be,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              busy
`ifdef DM_SLAVE_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`ifdef DM_SLAVE_ERR_EN
   localparam logic [31:0] OorData = 32'hDEAD_BEEF;
`else
   localparam logic [31:0] OorData = 32'h0;
`endif

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          be_q, be_d;
   logic                ready_q, ready_d;
   logic [31:0]         rdata_q, rdata_d;
`ifdef DM_SLAVE_ERR_EN
   logic                err_q, err_d;
`endif

   logic [31:0]         mem [DEPTH];

   logic                acc_en;
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_addr;
   logic [31:0]         acc_wdata;
   logic [3:0]          acc_be;
   logic                in_range;
   logic [MemAw-1:0]    mem_idx;

   // Select the access source: live inputs for zero-wait accepts, latched request otherwise.
   always_comb begin
      acc_en    = 1'b0;
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      if (state_q == StIdle && req && WAIT_CYCLES == 0) begin
         // Gate with rst so an edge seen during reset never commits a write.
         acc_en    = ~rst;
         acc_we    = we;
         acc_addr  = addr;
         acc_wdata = wdata;
         acc_be    = be;
      end else if (state_q == StWait && cnt_q == 4'd0) begin
         acc_en = ~rst;
      end
      in_range = 32'(acc_addr) < DEPTH;
      mem_idx  = acc_addr[MemAw-1:0];
   end

   // Next-state logic for the handshake FSM, request latch and registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      ready_d = 1'b0;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               be_d    = be;
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
                  ready_d = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = WaitInit;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (acc_en && !acc_we) begin
         rdata_d = in_range ? mem[mem_idx] : OorData;
      end
`ifdef DM_SLAVE_ERR_EN
      err_d = acc_en && !in_range;
`endif
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         be_q    <= 4'h0;
         ready_q <= 1'b0;
         rdata_q <= 32'h0;
`ifdef DM_SLAVE_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
`ifdef DM_SLAVE_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   // RAM write port with per-byte enables; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (acc_en && acc_we && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[mem_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_q;
   assign busy  = (state_q != StIdle);
`ifdef DM_SLAVE_ERR_EN
   assign err   = err_q;
`endif

endmodule

// File: doc/dm_wait_slave.md
Name: dm_wait_slave

Overview:
Responder side of the processor's data-memory interface. Services word-wide read and write requests from the multicycle core's load/store states through a req/ready handshake, with a configurable number of wait states. Sits between the core's memory-access control and a synchronous RAM array. Supersedes the zero-latency data memory so the controller can be exercised against realistic memory timing.

Parameters:
ADDR_W, 10, word-address width (byte address bits [ADDR_W+1:2]).
DEPTH, 1024, number of implemented 32-bit words; must be ≤ 2**ADDR_W.
WAIT_CYCLES, 2, wait states inserted before the access; legal range 0..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  1  request strobe; sampled only in IDLE.
we  in  1  1 = write, 0 = read; qualified by req.
addr  in  ADDR_W  word address.
wdata  in  32  write data.
be  in  4  byte enables; be[i] selects wdata[8i+7:8i].
ready  out  1  one-cycle pulse: access complete, rdata valid for reads.
rdata  out  32  registered read data; held until the next read completes.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, ready=0, rdata=32'h0, busy=0, wait counter=0. RAM contents are not reset. Reset mid-transaction aborts it; a write not yet committed is dropped.
- States: IDLE, WAIT, RESP.
- IDLE: on an edge with req=1, latch we/addr/wdata/be. WAIT_CYCLES>0: go to WAIT, counter=WAIT_CYCLES-1. WAIT_CYCLES=0: perform the access on this same edge using the live inputs, go to RESP.
- WAIT: counter decrements each edge. On the edge where counter==0, perform the access using the latched values and go to RESP.
- Access: write: for each i with be[i]=1, mem[addr][8i+7:8i] <= wdata byte i; be=4'b0000 is a legal no-op that still completes. Read: rdata <= mem[addr] (full word, be ignored); rdata unchanged on writes.
- RESP: ready=1 for exactly this one cycle; the next edge returns to IDLE unconditionally. req is ignored in WAIT and RESP. A request is only accepted in IDLE, so at least one IDLE cycle separates transactions.
- Latency: req accepted at edge E0 → ready high in the cycle after edge E0+WAIT_CYCLES. Throughput: one access per WAIT_CYCLES+2 cycles.
- The latched request is immune to input changes after E0.
- addr ≥ DEPTH: write dropped, read returns 32'h0, handshake completes normally (see optional feature).
- ready and busy are registered/state-decoded outputs, with no combinational path from req.

Optional Feature:
DM_SLAVE_ERR_EN. When defined, adds output port err (1 bit): err=1 in the RESP cycle of an access with addr ≥ DEPTH, 0 otherwise, reset 0. An out-of-range read returns rdata=32'hDEAD_BEEF, and out-of-range writes are dropped. When undefined, there is no err port: out-of-range reads return 32'h0, writes are dropped silently, and timing is identical.

Test Plan:
- Reset with WAIT_CYCLES=2: assert rst mid-WAIT after a write request to addr 5 → ready, busy and rdata drop to 0 immediately; a later read of addr 5 returns the prior content, so the aborted write did not commit.
- Write 32'h1234_5678 to addr 3, be=4'hF, then read addr 3 → ready exactly 3 cycles after each accepting edge (WAIT_CYCLES=2); rdata=32'h1234_5678; busy high for 3 cycles.
- Byte enables: after the test above, write 32'hAABB_CCDD to addr 3 with be=4'b0101 → read gives 32'h12BB_56DD; be=4'b0000 leaves the word unchanged and still pulses ready.
- WAIT_CYCLES=0: a read of addr 7 is accepted at E0 and ready is high the next cycle. req held high continuously → accepts occur every 2 cycles.
- Protocol robustness: after acceptance, change addr/wdata/we and pulse req during WAIT → the original access completes, with no extra ready pulse and no second access.
- Out of range with DEPTH=512: read addr 600 → rdata=32'h0 (macro off) or 32'hDEAD_BEEF with err=1 for one cycle (DM_SLAVE_ERR_EN on). A write to 600 does not alias into addr 88.
